spi_reg_ctrl: RTL
=================

# spi_reg_ctrl

Frame controller sitting behind the SPI slave byte engine: it interprets each SSEL-framed message as a command byte followed by data bytes and sequences accesses to a 128-entry register bank. On writes it issues one register write per received byte; on reads it fetches register data and hands it to the slave's transmit shift register in time for the next byte. It also supplies the status byte sent during the command byte and counts completed frames.

## Interface
- STATUS_BYTE, 8'h05, byte loaded for transmission at message start (shifted out during the command byte)
- clk  input  1  system clock (same clock that oversamples SCK/SSEL/MOSI)
- rst_n  input  1  asynchronous, active-low reset
- ssel_active  input  1  synchronized SSEL, high while message in progress
- start_msg  input  1  one-cycle pulse at SSEL falling edge
- end_msg  input  1  one-cycle pulse at SSEL rising edge
- rx_valid  input  1  one-cycle pulse: full byte received
- rx_byte  input  8  received byte, valid with rx_valid
- tx_load  output  1  one-cycle pulse: slave loads tx_byte into its shift register
- tx_byte  output  8  byte to transmit, valid with tx_load
- reg_addr  output  7  register bank address
- reg_we  output  1  one-cycle write strobe
- reg_wdata  output  8  write data, valid with reg_we
- reg_re  output  1  one-cycle read strobe
- reg_rdata  input  8  read data, valid the cycle after reg_re
- busy  output  1  high in any state other than IDLE
- frame_cnt  output  8  count of frames that completed with at least one data byte

## Operation
- Command byte: bit7 = 1 write / 0 read; bits 6:0 = start address.
- States: IDLE, CMD, WRITE, RD_FETCH, READ.
- IDLE: start_msg -> CMD; tx_load pulses with tx_byte = STATUS_BYTE.
- CMD: rx_valid -> latch rw and address into reg_addr. Write -> WRITE. Read -> RD_FETCH.
- WRITE: each rx_valid -> reg_we with reg_wdata = rx_byte at current reg_addr; address then advances.
- RD_FETCH: reg_re asserted one cycle, next cycle tx_load with tx_byte = reg_rdata -> READ; address then advances.
- READ: each rx_valid (content ignored) -> RD_FETCH for next address.
- Data-byte flag set on first data-phase rx_valid; on end_msg, if flag set, frame_cnt increments (wraps 8'hFF -> 8'h00); flag cleared.
- end_msg or ssel_active low in any state -> IDLE; pending fetch/load is dropped, no strobes issued that cycle.
- start_msg while not IDLE: abort current frame (no frame_cnt increment), restart in CMD with status load.
- rx_valid in IDLE ignored.
- Address increment is 7-bit: 7'h7F -> 7'h00.
- Reset: state IDLE; tx_load, tx_byte, reg_addr, reg_we, reg_wdata, reg_re, busy, frame_cnt all 0.

## Timing
- tx_load (status): cycle after start_msg.
- reg_we: cycle after rx_valid in WRITE; strobes single-cycle.
- reg_re: cycle after rx_valid (CMD read or READ); tx_load with read data the following cycle, i.e. 2 cycles after rx_valid.
- reg_addr stable from strobe cycle until the increment in the following cycle.
- rx_valid pulses are at least 16 clk apart; a fetch therefore always completes before the next byte.
- frame_cnt updates cycle after end_msg.
- busy follows state, registered.

## Configuration
- SPI_REG_CTRL_AUTOINC_EN defined: address increments after every data access (burst, wrapping at 7'h7F).
- Undefined: address fixed at the command address for the whole frame; repeated writes hit one register, repeated reads return the same register.

## Test plan
- Reset mid-write (rst_n low during WRITE) -> all outputs 0 immediately, state IDLE, frame_cnt 0.
- Frame 8'h83, 8'hAA, 8'h55 -> tx_load with 8'h05 after start; reg_we at addr 3 data AA, addr 4 data 55; frame_cnt = 1.
- Bank addr 10 = 8'h11, addr 11 = 8'h22; frame 8'h0A, x, x -> reg_re at 10 then tx_load 8'h11 two cycles after rx_valid; then tx_load 8'h22.
- Write burst from 8'hFF with three data bytes -> writes at 7F, 00, 01 (AUTOINC on); all at 7F with macro undefined.
- Command-only frame (8'h85 then end_msg) -> no reg_we, frame_cnt unchanged.
- SSEL deasserted between reg_re and tx_load -> no tx_load, state IDLE, busy 0 next cycle.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// ----------------------------------------------------------------------------
// spi_reg_ctrl
//
// Frame controller behind an SPI slave byte engine. Each SSEL-framed message
// is a command byte (bit7 = 1 write / 0 read, bits 6:0 = start address)
// followed by data bytes. Writes issue one register write per received byte.
// Reads fetch a register and hand it to the slave's transmit shift register
// before the next byte. The status byte is loaded at message start, and
// frames that carried at least one data byte are counted.
//
// Configuration macro: SPI_REG_CTRL_AUTOINC_EN
//   defined   - address advances after every data access (wraps 7'h7F->0)
//   undefined - address stays at the command address for the whole frame
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   ssel_active       synchronized SSEL, high while a message is in progress
//   start_msg/end_msg single-cycle pulses at SSEL falling/rising edge
//   rx_valid/rx_byte  received byte strobe and data
//   tx_load/tx_byte   load pulse and byte for the slave transmit register
//   reg_addr          register bank address
//   reg_we/reg_wdata  register write strobe and data
//   reg_re/reg_rdata  register read strobe; data valid the cycle after reg_re
//   busy              high whenever the controller is not idle
//   frame_cnt         count of completed frames with at least one data byte
// ----------------------------------------------------------------------------
module spi_reg_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ssel_active,
    input  logic       start_msg,
    input  logic       end_msg,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       tx_load,
    output logic [7:0] tx_byte,
    output logic [6:0] reg_addr,
    output logic       reg_we,
    output logic [7:0] reg_wdata,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    localparam logic [7:0] STATUS_BYTE = 8'h05;

`ifdef SPI_REG_CTRL_AUTOINC_EN
    localparam bit AutoInc = 1'b1;
`else
    localparam bit AutoInc = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        RD_FETCH,
        READ
    } state_e;

    state_e     state_q;
    logic       tx_load_q;
    logic [7:0] tx_byte_q;
    logic       rdsel_q;
    logic [6:0] reg_addr_q;
    logic       reg_we_q;
    logic [7:0] reg_wdata_q;
    logic       reg_re_q;
    logic       busy_q;
    logic [7:0] frame_cnt_q;
    logic       data_seen_q;

    // Read data arrives on reg_rdata in the same cycle tx_load is pulsed, so
    // tx_byte passes reg_rdata through for that cycle (rdsel_q) and the value
    // is captured into tx_byte_q on the following edge to keep tx_byte stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_load_q   <= 1'b0;
            tx_byte_q   <= '0;
            rdsel_q     <= 1'b0;
            reg_addr_q  <= '0;
            reg_we_q    <= 1'b0;
            reg_wdata_q <= '0;
            reg_re_q    <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            data_seen_q <= 1'b0;
        end else begin
            tx_load_q <= 1'b0;
            reg_we_q  <= 1'b0;
            reg_re_q  <= 1'b0;
            if (rdsel_q) begin
                tx_byte_q <= reg_rdata;
                rdsel_q   <= 1'b0;
            end

            if (start_msg) begin
                // New message (also aborts any frame in progress, uncounted)
                state_q     <= CMD;
                busy_q      <= 1'b1;
                tx_load_q   <= 1'b1;
                tx_byte_q   <= STATUS_BYTE;
                rdsel_q     <= 1'b0;
                data_seen_q <= 1'b0;
            end else if (state_q != IDLE && (end_msg || !ssel_active)) begin
                // Frame ends: any pending fetch/load is dropped
                state_q     <= IDLE;
                busy_q      <= 1'b0;
                rdsel_q     <= 1'b0;
                data_seen_q <= 1'b0;
                if (end_msg && data_seen_q)
                    frame_cnt_q <= frame_cnt_q + 8'd1;
            end else begin
                case (state_q)
                    IDLE: ;
                    CMD: begin
                        if (rx_valid) begin
                            reg_addr_q <= rx_byte[6:0];
                            if (rx_byte[7]) begin
                                state_q <= WRITE;
                            end else begin
                                state_q  <= RD_FETCH;
                                reg_re_q <= 1'b1;
                            end
                        end
                    end
                    WRITE: begin
                        // Advance on the edge that ends the write strobe
                        if (reg_we_q && AutoInc)
                            reg_addr_q <= reg_addr_q + 7'd1;
                        if (rx_valid) begin
                            reg_we_q    <= 1'b1;
                            reg_wdata_q <= rx_byte;
                            data_seen_q <= 1'b1;
                        end
                    end
                    RD_FETCH: begin
                        tx_load_q <= 1'b1;
                        rdsel_q   <= 1'b1;
                        state_q   <= READ;
                        if (AutoInc)
                            reg_addr_q <= reg_addr_q + 7'd1;
                    end
                    READ: begin
                        if (rx_valid) begin
                            data_seen_q <= 1'b1;
                            reg_re_q    <= 1'b1;
                            state_q     <= RD_FETCH;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_load   = tx_load_q;
    assign tx_byte   = rdsel_q ? reg_rdata : tx_byte_q;
    assign reg_addr  = reg_addr_q;
    assign reg_we    = reg_we_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_re    = reg_re_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

endmodule
